// File: rtl/free_list_pkg.sv
// Shared sizing for the physical-tag free list: tag width, list depth and pointer/count widths.
package free_list_pkg;

  localparam int unsigned PR        = 6;
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned FL_SIZE   = (2 ** PR) - ARCH_REGS;
  localparam int unsigned PTR_W     = $clog2(FL_SIZE);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned SUM_W     = CNT_W + 1;
  localparam int unsigned LANES     = 3;

endpackage

// File: rtl/free_list.sv
// Circular free list of physical tags for a 3-wide rename stage.
// Define FREE_LIST_ERR_EN to add a sticky fl_error flag for over-dispatch / over-retire.
module free_list
  import free_list_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic [LANES-1:0]         DispatchEN,
  input  logic [LANES-1:0]         RetireEN,
  input  logic [LANES-1:0][PR-1:0] Told_in,
  input  logic                     BPRecoverEN,
  output logic [LANES-1:0][PR-1:0] free_pr_out,
  output logic [1:0]               free_num
`ifdef FREE_LIST_ERR_EN
  ,
  output logic                     fl_error
`endif
);

  // Number of enabled lanes strictly below 'lane'; lane = 3 gives the full popcount.
  function automatic logic [1:0] ones_below(input logic [2:0] en, input logic [1:0] lane);
    logic [1:0] n;
    n = 2'd0;
    if ((lane > 2'd0) && en[0]) n = n + 2'd1;
    if ((lane > 2'd1) && en[1]) n = n + 2'd1;
    if ((lane > 2'd2) && en[2]) n = n + 2'd1;
    return n;
  endfunction

  logic [PR-1:0]    buf_q [FL_SIZE];
  logic [PR-1:0]    buf_d [FL_SIZE];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       disp_n;
  logic [1:0]       ret_n;
  logic [SUM_W-1:0] grow;
  logic [SUM_W-1:0] net;

  // Read side depends only on current state, so a tag freed this cycle is not visible yet.
  always_comb begin
    free_pr_out[0] = buf_q[head_q];
    free_pr_out[1] = buf_q[head_q + PTR_W'(1)];
    free_pr_out[2] = buf_q[head_q + PTR_W'(2)];
    free_num       = (count_q >= CNT_W'(3)) ? 2'd3 : count_q[1:0];
  end

  always_comb begin
    disp_n = ones_below(DispatchEN, 2'd3);
    ret_n  = ones_below(RetireEN, 2'd3);

    // Retiring lanes are packed into consecutive slots from tail, oldest first.
    buf_d = buf_q;
    if (RetireEN[0]) buf_d[tail_q + PTR_W'(ones_below(RetireEN, 2'd0))] = Told_in[0];
    if (RetireEN[1]) buf_d[tail_q + PTR_W'(ones_below(RetireEN, 2'd1))] = Told_in[1];
    if (RetireEN[2]) buf_d[tail_q + PTR_W'(ones_below(RetireEN, 2'd2))] = Told_in[2];
    tail_d = tail_q + PTR_W'(ret_n);

    grow = {1'b0, count_q} + SUM_W'(ret_n);
    net  = grow - SUM_W'(disp_n);

    // Recovery hands back every slot between the new tail and head; dispatch is ignored.
    if (BPRecoverEN) begin
      head_d  = tail_d;
      count_d = CNT_W'(FL_SIZE);
    end else begin
      head_d = head_q + PTR_W'(disp_n);
      if (grow < SUM_W'(disp_n)) begin
        count_d = '0;
      end else if (net > SUM_W'(FL_SIZE)) begin
        count_d = CNT_W'(FL_SIZE);
      end else begin
        count_d = CNT_W'(net);
      end
    end
  end

`ifdef FREE_LIST_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (!BPRecoverEN &&
        ((disp_n > free_num) || (grow > (SUM_W'(FL_SIZE) + SUM_W'(disp_n))))) begin
      err_d = 1'b1;
    end
  end

  assign fl_error = err_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < FL_SIZE; i++) begin
        buf_q[PTR_W'(i)] <= PR'(ARCH_REGS + i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(FL_SIZE);
`ifdef FREE_LIST_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      buf_q   <= buf_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
`ifdef FREE_LIST_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: queue-based reference model, directed scenarios, random traffic.
module tb_free_list;
  import free_list_pkg::*;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [LANES-1:0]         DispatchEN;
  logic [LANES-1:0]         RetireEN;
  logic [LANES-1:0][PR-1:0] Told_in;
  logic                     BPRecoverEN;
  logic [LANES-1:0][PR-1:0] free_pr_out;
  logic [1:0]               free_num;
`ifdef FREE_LIST_ERR_EN
  logic                     fl_error;
`endif

  free_list dut (
    .clock       (clock),
    .reset       (reset),
    .DispatchEN  (DispatchEN),
    .RetireEN    (RetireEN),
    .Told_in     (Told_in),
    .BPRecoverEN (BPRecoverEN),
    .free_pr_out (free_pr_out),
    .free_num    (free_num)
`ifdef FREE_LIST_ERR_EN
    ,
    .fl_error    (fl_error)
`endif
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Model: fq = free tags in dispatch order; hist = tags handed out since the last recovery.
  int fq[$];
  int hist[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    fq.delete();
    hist.delete();
    for (int i = 0; i < 32; i++) fq.push_back(32 + i);
  endfunction

  function automatic void model_step(input logic [2:0] d, input logic [2:0] r,
                                     input logic [2:0][PR-1:0] t, input logic rec,
                                     input logic rs);
    int rl[$];
    int nq[$];
    int k;
    if (rs) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) if (r[2'(i)]) rl.push_back(int'(t[2'(i)]));
    if (rec) begin
      // Tags dispatched but not yet overwritten by retirement come back first, in dispatch order.
      k = 32 - (fq.size() + rl.size());
      if (k < 0) k = 0;
      if (k > hist.size()) k = hist.size();
      for (int i = hist.size() - k; i < hist.size(); i++) nq.push_back(hist[i]);
      foreach (fq[i]) nq.push_back(fq[i]);
      foreach (rl[i]) nq.push_back(rl[i]);
      fq = nq;
      hist.delete();
    end else begin
      for (int i = 0; i < $countones(d); i++) if (fq.size() > 0) hist.push_back(fq.pop_front());
      foreach (rl[i]) fq.push_back(rl[i]);
      while (hist.size() > 64) void'(hist.pop_front());
    end
  endfunction

  task automatic cycle(input logic [2:0] d, input logic [2:0] r, input int t0, input int t1,
                       input int t2, input logic rec, input logic rs);
    DispatchEN  = d;
    RetireEN    = r;
    Told_in     = {PR'(t2), PR'(t1), PR'(t0)};
    BPRecoverEN = rec;
    reset       = rs;
    @(posedge clock);
    model_step(d, r, {PR'(t2), PR'(t1), PR'(t0)}, rec, rs);
    #1;
  endtask

  // Every-cycle comparison against the model on the lanes that are meaningful.
  always @(negedge clock) begin
    int en;
    if (chk_en) begin
      en = (fq.size() > 3) ? 3 : fq.size();
      check("free_num", int'(free_num), en);
      for (int i = 0; i < en; i++)
        check($sformatf("free_pr_out[%0d]", i), int'(free_pr_out[2'(i)]), fq[i]);
    end
  end

  initial begin
    model_reset();
    cycle(3'b000, 3'b000, 0, 0, 0, 1'b0, 1'b1);
    chk_en = 1'b1;
    check("rst_num", int'(free_num), 3);
    check("rst_lane0", int'(free_pr_out[0]), 32);
    check("rst_lane1", int'(free_pr_out[1]), 33);
    check("rst_lane2", int'(free_pr_out[2]), 34);

    // Thirty tags out, two left.
    repeat (10) cycle(3'b111, 3'b000, 0, 0, 0, 1'b0, 1'b0);
    check("d30_num", int'(free_num), 2);
    check("d30_lane0", int'(free_pr_out[0]), 62);
    check("d30_lane1", int'(free_pr_out[1]), 63);

    // Empty list: a freed tag must not bypass into the same cycle.
    cycle(3'b011, 3'b000, 0, 0, 0, 1'b0, 1'b0);
    check("drained_num", int'(free_num), 0);
    DispatchEN  = 3'b000;
    RetireEN    = 3'b001;
    Told_in     = {PR'(0), PR'(0), PR'(5)};
    BPRecoverEN = 1'b0;
    #1;
    check("no_bypass_num", int'(free_num), 0);
    cycle(3'b000, 3'b001, 5, 0, 0, 1'b0, 1'b0);
    check("freed_num", int'(free_num), 1);
    check("freed_lane0", int'(free_pr_out[0]), 5);

    // Wrap: drain all 32, retire 0..31, head comes around to slot 0.
    cycle(3'b000, 3'b000, 0, 0, 0, 1'b0, 1'b1);
    repeat (10) cycle(3'b111, 3'b000, 0, 0, 0, 1'b0, 1'b0);
    cycle(3'b011, 3'b000, 0, 0, 0, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) cycle(3'b000, 3'b111, 3 * j, 3 * j + 1, 3 * j + 2, 1'b0, 1'b0);
    cycle(3'b000, 3'b011, 30, 31, 0, 1'b0, 1'b0);
    check("wrap_num", int'(free_num), 3);
    check("wrap_lane0", int'(free_pr_out[0]), 0);
    check("wrap_lane1", int'(free_pr_out[1]), 1);
    check("wrap_lane2", int'(free_pr_out[2]), 2);
    cycle(3'b111, 3'b101, 40, 0, 41, 1'b0, 1'b0);
    check("wrap_next_lane0", int'(free_pr_out[0]), 3);

    // Recovery with a simultaneous retire; dispatch that cycle is ignored.
    cycle(3'b000, 3'b000, 0, 0, 0, 1'b0, 1'b1);
    repeat (3) cycle(3'b111, 3'b000, 0, 0, 0, 1'b0, 1'b0);
    cycle(3'b111, 3'b001, 7, 0, 0, 1'b1, 1'b0);
    check("rec_num", int'(free_num), 3);
    check("rec_lane0", int'(free_pr_out[0]), 33);
    check("rec_lane1", int'(free_pr_out[1]), 34);
    check("rec_lane2", int'(free_pr_out[2]), 35);
    repeat (10) cycle(3'b111, 3'b000, 0, 0, 0, 1'b0, 1'b0);
    cycle(3'b001, 3'b000, 0, 0, 0, 1'b0, 1'b0);
    check("rec_tag7_num", int'(free_num), 1);
    check("rec_tag7_lane0", int'(free_pr_out[0]), 7);

    // Reset wins over everything else in the same cycle.
    cycle(3'b111, 3'b111, 1, 2, 3, 1'b1, 1'b1);
    check("rst_prio_num", int'(free_num), 3);
    check("rst_prio_lane0", int'(free_pr_out[0]), 32);

`ifdef FREE_LIST_ERR_EN
    check("err_rst", int'(fl_error), 0);
    repeat (10) cycle(3'b111, 3'b000, 0, 0, 0, 1'b0, 1'b0);
    check("err_legal", int'(fl_error), 0);
    chk_en = 1'b0;
    cycle(3'b111, 3'b000, 0, 0, 0, 1'b0, 1'b0);
    check("err_set", int'(fl_error), 1);
    repeat (3) cycle(3'b000, 3'b000, 0, 0, 0, 1'b0, 1'b0);
    check("err_sticky", int'(fl_error), 1);
    cycle(3'b000, 3'b000, 0, 0, 0, 1'b0, 1'b1);
    chk_en = 1'b1;
    check("err_cleared", int'(fl_error), 0);
`endif

    // Random legal traffic with occasional recovery and reset.
    for (int c = 0; c < 3000; c++) begin
      int n, fm, dn, rm;
      logic [2:0] d, r;
      logic rec, rs;
      n  = fq.size();
      fm = (n < 3) ? n : 3;
      dn = int'($urandom_range(fm, 0));
      d  = (dn == 0) ? 3'b000 : (dn == 1) ? 3'b001 : (dn == 2) ? 3'b011 : 3'b111;
      rm = 32 - n;
      if (rm > 3) rm = 3;
      do r = 3'($urandom); while ($countones(r) > rm);
      rec = ($urandom_range(15, 0) == 0);
      rs  = ($urandom_range(499, 0) == 0);
      cycle(d, r, int'($urandom_range(63, 0)), int'($urandom_range(63, 0)),
            int'($urandom_range(63, 0)), rec, rs);
    end

    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameters: none; sizing from shared header (`PR physical-tag width, `FL_SIZE = 2**`PR - 32 entries, default 32).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 DispatchEN  in  [2:0]  lanes renaming a destination this cycle; legal values 000/001/011/111.
REQ-006 RetireEN  in  [2:0]  lanes retiring an instruction with a destination; lane order = age order.
REQ-007 Told_in  in  [2:0][`PR-1:0]  old physical tag freed by retiring lane i.
REQ-008 BPRecoverEN  in  1  precise-state recovery pulse, same as the map table's.
REQ-009 free_pr_out  out  [2:0][`PR-1:0]  lane i = entry at head+i; feeds maptable_new_pr.
REQ-010 free_num  out  [1:0]  min(count,3); lanes allowed to dispatch.

Function
REQ-011 Storage: circular buffer of `FL_SIZE tags, head (read) and tail (write) pointers of clog2(`FL_SIZE) bits wrapping mod `FL_SIZE, count of clog2(`FL_SIZE)+1 bits.
REQ-012 free_pr_out and free_num are combinational from current head/count/buffer only; no dependence on same-cycle inputs.
REQ-013 Dispatch: head advances by popcount(DispatchEN) at the clock edge; consumed slot contents are not cleared.
REQ-014 Retire: for each set RetireEN[i] in lane order, Told_in[i] written at tail+k (k = set lanes below i); tail advances by popcount(RetireEN).
REQ-015 count_next = count - popcount(DispatchEN) + popcount(RetireEN) when no recovery.
REQ-016 A tag freed in cycle N is dispatchable no earlier than cycle N+1; no same-cycle bypass.
REQ-017 Dispatch with popcount(DispatchEN) > free_num is illegal; count saturates at 0, head still advances.
REQ-018 Retire making count exceed `FL_SIZE is illegal; count saturates at `FL_SIZE.
REQ-019 BPRecoverEN: retire writes of that cycle complete first; then head <= tail_next, count <= `FL_SIZE; DispatchEN ignored that cycle.
REQ-020 Recovery correctness: slots [tail, head) hold Tnew of dispatched-not-retired instructions, so head <= tail returns exactly those to the free pool.
REQ-021 Wrap-around: pointer arithmetic mod `FL_SIZE for every lane, including dispatch/retire straddling slot `FL_SIZE-1 -> 0.

Reset
REQ-022 On reset, slot i <= 32+i, head <= 0, tail <= 0, count <= `FL_SIZE.
REQ-023 After reset, free_pr_out = {34,33,32} (lane2..0), free_num = 3.
REQ-024 Reset has priority over BPRecoverEN, dispatch and retire in the same cycle.

Configuration
REQ-025 Macro FREE_LIST_ERR_EN: when defined, output fl_error (1 bit) is present.
REQ-026 fl_error is set on any REQ-017/REQ-018 violation, sticky until reset, reset value 0.
REQ-027 Without FREE_LIST_ERR_EN, no fl_error port exists and no checking logic is synthesized; saturation behaviour is unchanged.

Structure
REQ-028 `PR, `FL_SIZE and `SD live in the shared sys_defs header; no new typedefs are needed.
REQ-029 Single module; no sub-module. A 3-lane popcount/offset function is local to the module.
REQ-030 All state is updated in one clocked process with `SD; next-state logic is combinational.

Verification
REQ-031 Reset -> free_pr_out = {34,33,32}, free_num = 3, count = 32.
REQ-032 DispatchEN = 111 for 10 cycles -> count = 2, free_num = 2, free_pr_out[0] = 62, free_pr_out[1] = 63.
REQ-033 Drain to count = 0; retire Told_in[0] = 5 with free_num = 0 -> free_num still 0 that cycle; next cycle free_num = 1, free_pr_out[0] = 5.
REQ-034 Wrap: dispatch all 32 entries, retire Told 0..31 -> dispatch returns 0, 1, 2 from slots 0-2 after head wraps.
REQ-035 Recovery: dispatch 3x111 (tags 32..40); next cycle RetireEN = 001, Told_in[0] = 7, BPRecoverEN = 1 -> count = 32, head = tail = 1, free_pr_out = {35,34,33}; tag 7 reappears after 31 dispatches.
REQ-036 With FREE_LIST_ERR_EN: DispatchEN = 111 at count = 2 -> fl_error = 1 next cycle and stays 1 until reset.
